io_bridge: RTL and testbench

Memory-bus bridge directly downstream of the CPU top's byte-wide memory port (`mem_a`, `mem_dout`, `mem_wr`, `mem_din`, `io_buffer_full`). It decodes each bus cycle to RAM or memory-mapped I/O, and passes RAM traffic through. It buffers UART output bytes in a FIFO, serves UART input and cycle-counter reads with the CPU's one-cycle read latency, and raises the program-stop flag. It also drives `io_buffer_full` back to the CPU.

---
 rtl/io_bridge_pkg.sv | 23 ++
 rtl/io_bridge_fifo.sv | 55 +++++
 rtl/io_bridge.sv | 143 ++++++++++++++
 tb/tb_io_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// io_bridge shared definitions: I/O map, region mask, read-select enum.
// Imported by the bridge top and its TX FIFO.
package io_bridge_pkg;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;
  localparam logic [1:0]  IO_REGION    = 2'b11;

  typedef enum logic {
    SEL_RAM,
    SEL_IO
  } io_sel_e;

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  k
  );
    logic [31:0] s;
    s = w >> {k, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/io_bridge_fifo.sv
// Synchronous byte FIFO for UART transmit data.
// Pointers carry one extra wrap bit so full/empty come from the difference.
module byte_fifo
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    count   = wptr_q - rptr_q;
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot for a push into a full FIFO
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
    dout    = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// CPU memory-bus bridge: RAM pass-through, UART TX FIFO / RX read,
// cycle counter with coherent shadow, stop flag and back-pressure.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [17:0]   a;
  logic          unused_hi;
  logic          is_io, rd_io, wr_io;
  logic          is_uart, is_ctrl, is_cnt;
  logic          fifo_push, fifo_pop, push_ok;
  logic [7:0]    fifo_din;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count, count_next;

  io_sel_e       rsel_q, rsel_d;
  logic [7:0]    io_rdata_q, io_rdata_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          bfull_q, bfull_d;

  assign a         = cpu_a[17:0];
  assign unused_hi = ^cpu_a[31:18];

  always_comb begin
    is_io    = (a[17:16] == IO_REGION);
    rd_io    = is_io & ~cpu_wr;
    wr_io    = is_io & cpu_wr;
    is_uart  = (a == IO_UART_ADDR);
    is_ctrl  = (a == IO_CTRL_ADDR);
    is_cnt   = (a[17:2] == IO_CTRL_ADDR[17:2]);
    ram_a    = cpu_a[16:0];
    ram_dout = cpu_dout;
    ram_wr   = cpu_wr & ~is_io;
    rx_pop   = rd_io & is_uart & rx_valid;

    fifo_push = 1'b0;
    fifo_din  = cpu_dout;
    if (wr_io && is_uart && cpu_dout != 8'h00) begin
      fifo_push = 1'b1;
    end
    // the stop marker is a literal zero and must not be filtered
    if (wr_io && is_ctrl) begin
      fifo_push = 1'b1;
      fifo_din  = 8'h00;
    end

    io_rdata_d = 8'h00;
    shadow_d   = shadow_q;
    if (rd_io) begin
      unique case (1'b1)
        is_uart: io_rdata_d = rx_valid ? rx_data : 8'h00;
        is_cnt: begin
          if (a[1:0] == 2'd0) begin
            io_rdata_d = cnt_q[7:0];
            shadow_d   = cnt_q;
          end else begin
            io_rdata_d = byte_of(shadow_q, a[1:0]);
          end
        end
        default: io_rdata_d = 8'h00;
      endcase
    end

    rsel_d = rd_io ? SEL_IO : SEL_RAM;
    cnt_d  = cnt_q + 32'd1;
    done_d = done_q | (wr_io & is_ctrl);

    tx_valid   = ~fifo_empty;
    fifo_pop   = tx_valid & tx_ready;
    push_ok    = fifo_push & (~fifo_full | fifo_pop);
    ovf_d      = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
    count_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    bfull_d    = (count_next >= CW'(FIFO_DEPTH - FULL_MARGIN));

    cpu_din        = (rsel_q == SEL_IO) ? io_rdata_q : ram_din;
    io_buffer_full = bfull_q;
    program_done   = done_q;
    tx_overflow    = ovf_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rsel_q     <= SEL_RAM;
      io_rdata_q <= 8'h00;
      cnt_q      <= 32'd0;
      shadow_q   <= 32'd0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bfull_q    <= 1'b0;
    end else begin
      rsel_q     <= rsel_d;
      io_rdata_q <= io_rdata_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bfull_q    <= bfull_d;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: vector table plus read scoreboard
// and hand-written TX / counter / reset sequences.
module tb_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_done;
  logic        tx_overflow;

  io_bridge dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .cpu_a         (cpu_a),
    .cpu_dout      (cpu_dout),
    .cpu_wr        (cpu_wr),
    .cpu_din       (cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a         (ram_a),
    .ram_dout      (ram_dout),
    .ram_wr        (ram_wr),
    .ram_din       (ram_din),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_pop        (rx_pop),
    .program_done  (program_done),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // small RAM model with one-cycle read latency
  logic [7:0] ram_mem [1024] = '{default: 8'h00};
  always @(posedge clk_in) begin
    if (ram_wr) ram_mem[ram_a[9:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[9:0]];
  end

  // reference cycle counter
  logic [31:0] mcnt = 32'd0;
  always @(posedge clk_in) mcnt <= !rst_in ? 32'd0 : mcnt + 32'd1;

  // bytes the UART accepts, sampled mid-cycle before the popping edge
  logic [7:0] got_q [$];
  logic [7:0] exp_tx [$];
  always @(negedge clk_in) begin
    if (rst_in && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  logic [7:0] sb_q [$];
  string      sbn_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (sb_q.size() > 0) begin
      chk(sbn_q.pop_front(), 32'(cpu_din), 32'(sb_q.pop_front()));
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w,
                         input logic [7:0] d);
    cpu_a    = a;
    cpu_wr   = w;
    cpu_dout = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e,
                    input string nm);
    set_bus(a, 1'b0, 8'h00);
    sb_q.push_back(e);
    sbn_q.push_back(nm);
    tick();
  endtask

  task automatic wr_io(input logic [31:0] a, input logic [7:0] d);
    set_bus(a, 1'b1, d);
    #1;
    chk("io_wr_ram_wr", 32'(ram_wr), 32'd0);
    tick();
  endtask

  task automatic cmp_tx(input string nm);
    chk({nm, "_len"}, 32'(got_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_%0d", nm, i), 32'(got_q[i]), 32'(exp_tx[i]));
    end
    got_q.delete();
    exp_tx.delete();
  endtask

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        rxv;
    logic [7:0]  rxd;
    logic        e_ram_wr;
    logic        e_rx_pop;
    logic [7:0]  e_din;
    string       nm;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0000_0100, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "ram_write"};
    vt[1] = '{32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, "ram_read"};
    vt[2] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h37, 1'b0, 1'b1, 8'h37, "rx_read"};
    vt[3] = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00, "rx_empty"};
    vt[4] = '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, "io_other_rd"};
    vt[5] = '{32'h0003_0008, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "io_other_wr"};
    vt[6] = '{32'hFFFC_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, "ram_hi_bits"};
    vt[7] = '{32'h0002_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, "ram_a17_10"};

    rst_in   = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    set_bus(32'h0, 1'b0, 8'h00);
    tick();
    tick();
    chk("rst_cpu_din", 32'(cpu_din), 32'd0);
    chk("rst_bfull", 32'(io_buffer_full), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_pop", 32'(rx_pop), 32'd0);
    chk("rst_done", 32'(program_done), 32'd0);
    chk("rst_ovf", 32'(tx_overflow), 32'd0);
    rst_in = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_bus(vt[i].a, vt[i].wr, vt[i].dout);
      rx_valid = vt[i].rxv;
      rx_data  = vt[i].rxd;
      #1;
      chk({vt[i].nm, "_ram_wr"}, 32'(ram_wr), 32'(vt[i].e_ram_wr));
      chk({vt[i].nm, "_rx_pop"}, 32'(rx_pop), 32'(vt[i].e_rx_pop));
      if (!vt[i].wr) begin
        sb_q.push_back(vt[i].e_din);
        sbn_q.push_back({vt[i].nm, "_din"});
      end
      tick();
      chk({vt[i].nm, "_tx_valid"}, 32'(tx_valid), 32'd0);
    end
    rx_valid = 1'b0;
    set_bus(32'h0, 1'b0, 8'h00);
    tick();

    // UART write filtering
    tx_ready = 1'b1;
    got_q.delete();
    exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h42);
    wr_io(32'h0003_0000, 8'h41);
    chk("flt_vis_valid", 32'(tx_valid), 32'd1);
    chk("flt_vis_data", 32'(tx_data), 32'h41);
    wr_io(32'h0003_0000, 8'h00);
    chk("flt_zero_valid", 32'(tx_valid), 32'd0);
    wr_io(32'h0003_0000, 8'h42);
    set_bus(32'h0, 1'b0, 8'h00);
    repeat (4) tick();
    cmp_tx("flt_tx");

    // back-pressure, full push+pop, overflow
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      wr_io(32'h0003_0000, 8'(i));
      exp_tx.push_back(8'(i));
      chk($sformatf("bp_bfull_%0d", i), 32'(io_buffer_full), 32'(i >= 14));
    end
    chk("bp_ovf_at_16", 32'(tx_overflow), 32'd0);
    tx_ready = 1'b1;
    wr_io(32'h0003_0000, 8'h20);
    exp_tx.push_back(8'h20);
    tx_ready = 1'b0;
    chk("bp_pushpop_ovf", 32'(tx_overflow), 32'd0);
    chk("bp_pushpop_bfull", 32'(io_buffer_full), 32'd1);
    chk("bp_pushpop_head", 32'(tx_data), 32'd2);
    wr_io(32'h0003_0000, 8'h21);
    chk("bp_ovf_set", 32'(tx_overflow), 32'd1);
    set_bus(32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("bp_drain_bfull_%0d", k), 32'(io_buffer_full), 32'(k <= 2));
    end
    repeat (16) tick();
    chk("bp_drained_valid", 32'(tx_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(tx_overflow), 32'd1);
    cmp_tx("bp_tx");

    // stop write, then reset mid-operation
    tx_ready = 1'b0;
    wr_io(32'h0003_0004, 8'h55);
    chk("stop_done", 32'(program_done), 32'd1);
    chk("stop_valid", 32'(tx_valid), 32'd1);
    chk("stop_data", 32'(tx_data), 32'h00);
    set_bus(32'h0, 1'b0, 8'h00);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    chk("rst2_cpu_din", 32'(cpu_din), 32'd0);
    chk("rst2_bfull", 32'(io_buffer_full), 32'd0);
    chk("rst2_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst2_rx_pop", 32'(rx_pop), 32'd0);
    chk("rst2_done", 32'(program_done), 32'd0);
    chk("rst2_ovf", 32'(tx_overflow), 32'd0);

    // counter coherence
    begin
      logic [31:0] e;
      repeat (32'h100) tick();
      e = mcnt;
      rd(32'h0003_0004, e[7:0], "cnt_b0");
      rd(32'h0003_0005, e[15:8], "cnt_b1");
      rd(32'h0003_0006, e[23:16], "cnt_b2");
      rd(32'h0003_0007, e[31:24], "cnt_b3");
      set_bus(32'h0, 1'b0, 8'h00);
      for (int k = 0; k < 1000 && mcnt != 32'h1FF; k++) tick();
      e = mcnt;
      rd(32'h0003_0004, e[7:0], "cnt2_b0");
      rd(32'h0003_0005, e[15:8], "cnt2_b1");
      rd(32'h0003_0006, e[23:16], "cnt2_b2");
      rd(32'h0003_0007, e[31:24], "cnt2_b3");
    end

    // counter wrap
    set_bus(32'h0003_0004, 1'b0, 8'h00);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    sb_q.push_back(8'hFF);
    sbn_q.push_back("wrap_b0");
    tick();
    rd(32'h0003_0007, 8'hFF, "wrap_shadow_b3");
    rd(32'h0003_0004, 8'h01, "wrap_live_b0");
    rd(32'h0003_0005, 8'h00, "wrap_after_b1");
    set_bus(32'h0, 1'b0, 8'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
